packet_scheduler: RTL

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/packet_scheduler_if.sv | 43 ++++
 rtl/packet_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/packet_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : packet_scheduler_if
// Description : Bundle of all data-path signals of packet_scheduler. The
//               scheduler sits on the slave modport. The audio source and
//               packet consumer sit on the master modport.
//   frame_start    source -> sched   1  one-cycle pulse at frame start
//   packet_slot    source -> sched   1  one-cycle pulse, packet slot granted
//   audio_valid    source -> sched   1  source offers a stereo pair
//   audio_ready    sched  -> source  1  FIFO can accept a pair
//   audio_left/right source -> sched 24 L-PCM sample words
//   packet_valid   sched  -> sink    1  packet_type / samples valid
//   packet_type    sched  -> sink    8  HDMI packet header byte 0
//   sample_left/right sched -> sink  24 stereo pair for audio sample packet
//   fifo_level     sched  -> sink    5  FIFO occupancy
// Revision    : 1.0  initial release
// ============================================================================
interface packet_scheduler_if;
    logic        frame_start;
    logic        packet_slot;
    logic        audio_valid;
    logic        audio_ready;
    logic [23:0] audio_left;
    logic [23:0] audio_right;
    logic        packet_valid;
    logic [7:0]  packet_type;
    logic [23:0] sample_left;
    logic [23:0] sample_right;
    logic [4:0]  fifo_level;

    modport slave (
        input  frame_start, packet_slot, audio_valid, audio_left, audio_right,
        output audio_ready, packet_valid, packet_type, sample_left,
               sample_right, fifo_level
    );

    modport master (
        output frame_start, packet_slot, audio_valid, audio_left, audio_right,
        input  audio_ready, packet_valid, packet_type, sample_left,
               sample_right, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : packet_scheduler
// Description : HDMI data-island packet scheduler. Buffers stereo audio pairs
//               in a small FIFO, raises an Audio Clock Regeneration request
//               every ACR_PERIOD pixel clocks, and on each granted packet slot
//               picks one packet: ACR > audio sample > AVI InfoFrame >
//               Audio InfoFrame > null.
// Ports       : clk_pixel  in   pixel clock, rising edge
//               reset_n    in   asynchronous active-low reset
//               bus        slave modport of packet_scheduler_if (frame_start,
//                          packet_slot, audio stream in, packet stream out,
//                          fifo_level)
// Parameters  : ACR_PERIOD  clk_pixel cycles between ACR requests
//               FIFO_DEPTH  audio FIFO depth in pairs (power of two, 2..16)
// Macro       : PACKET_SCHEDULER_INFOFRAME_EN - when defined, frame_start
//               schedules AVI (0x82) and Audio (0x84) InfoFrames; when
//               undefined frame_start is ignored and those types never appear.
// Revision    : 1.0  initial release
// ============================================================================
module packet_scheduler #(
    parameter int ACR_PERIOD = 25200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_pixel,
    input  logic                reset_n,
    packet_scheduler_if.slave   bus
);

    localparam int         c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int         c_CNT_W      = (ACR_PERIOD > 1) ? $clog2(ACR_PERIOD) : 1;
    localparam logic [4:0] c_DEPTH      = 5'(FIFO_DEPTH);
    localparam logic [7:0] c_TYPE_NULL  = 8'h00;
    localparam logic [7:0] c_TYPE_ACR   = 8'h01;
    localparam logic [7:0] c_TYPE_AUDIO = 8'h02;
    localparam logic [7:0] c_TYPE_AVI   = 8'h82;
    localparam logic [7:0] c_TYPE_AIF   = 8'h84;

    // FIFO state
    logic [23:0]         r_mem_left  [FIFO_DEPTH];
    logic [23:0]         r_mem_right [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [4:0]          r_level;
    logic                r_ready;

    // ACR request generation
    logic [c_CNT_W-1:0]  r_acr_cnt;
    logic                r_acr_pending;

    // Registered packet outputs
    logic                r_packet_valid;
    logic [7:0]          r_packet_type;
    logic [23:0]         r_sample_left;
    logic [23:0]         r_sample_right;

    // Combinational control
    logic                w_push;
    logic                w_pop;
    logic                w_wrap;
    logic                w_acr_sent;
    logic                w_avi_sent;
    logic                w_aif_sent;
    logic                w_avi_pending;
    logic                w_aif_pending;
    logic [7:0]          w_sel_type;
    logic [4:0]          w_level_next;

    // Selection uses only registered level/flags, so a pair pushed in the
    // slot cycle is never eligible for that same slot.
    always_comb begin
        w_sel_type = c_TYPE_NULL;
        if (r_acr_pending) begin
            w_sel_type = c_TYPE_ACR;
        end else if (r_level != 5'd0) begin
            w_sel_type = c_TYPE_AUDIO;
        end else if (w_avi_pending) begin
            w_sel_type = c_TYPE_AVI;
        end else if (w_aif_pending) begin
            w_sel_type = c_TYPE_AIF;
        end
    end

    assign w_push     = bus.audio_valid && r_ready;
    assign w_pop      = bus.packet_slot && (w_sel_type == c_TYPE_AUDIO);
    assign w_acr_sent = bus.packet_slot && (w_sel_type == c_TYPE_ACR);
    assign w_avi_sent = bus.packet_slot && (w_sel_type == c_TYPE_AVI);
    assign w_aif_sent = bus.packet_slot && (w_sel_type == c_TYPE_AIF);
    assign w_wrap     = (r_acr_cnt == c_CNT_W'(ACR_PERIOD - 1));

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + 5'd1;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - 5'd1;
        end
    end

    // Sample storage carries no reset; emptiness is tracked by the pointers
    // and level alone.
    always_ff @(posedge clk_pixel) begin
        if (w_push) begin
            r_mem_left[r_wr_ptr]  <= bus.audio_left;
            r_mem_right[r_wr_ptr] <= bus.audio_right;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= 5'd0;
            r_ready        <= 1'b0;
            r_acr_cnt      <= '0;
            r_acr_pending  <= 1'b0;
            r_packet_valid <= 1'b0;
            r_packet_type  <= c_TYPE_NULL;
            r_sample_left  <= 24'd0;
            r_sample_right <= 24'd0;
        end else begin
            // Power-of-two depth lets the pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr       <= r_rd_ptr + c_PTR_W'(1);
                r_sample_left  <= r_mem_left[r_rd_ptr];
                r_sample_right <= r_mem_right[r_rd_ptr];
            end
            r_level <= w_level_next;
            // Registered ready stays low through reset and rises on the
            // first edge afterwards.
            r_ready <= (w_level_next != c_DEPTH);

            r_acr_cnt     <= w_wrap ? '0 : r_acr_cnt + c_CNT_W'(1);
            // A wrap coinciding with the ACR send keeps the request alive.
            r_acr_pending <= w_wrap || (r_acr_pending && !w_acr_sent);

            r_packet_valid <= bus.packet_slot;
            if (bus.packet_slot) begin
                r_packet_type <= w_sel_type;
            end
        end
    end

`ifdef PACKET_SCHEDULER_INFOFRAME_EN
    logic r_avi_pending;
    logic r_aif_pending;

    // frame_start wins over a same-cycle InfoFrame send.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_avi_pending <= 1'b0;
            r_aif_pending <= 1'b0;
        end else begin
            r_avi_pending <= bus.frame_start || (r_avi_pending && !w_avi_sent);
            r_aif_pending <= bus.frame_start || (r_aif_pending && !w_aif_sent);
        end
    end

    assign w_avi_pending = r_avi_pending;
    assign w_aif_pending = r_aif_pending;
`else
    logic w_unused;

    assign w_avi_pending = 1'b0;
    assign w_aif_pending = 1'b0;
    assign w_unused      = &{1'b0, bus.frame_start, w_avi_sent, w_aif_sent};
`endif

    assign bus.audio_ready  = r_ready;
    assign bus.packet_valid = r_packet_valid;
    assign bus.packet_type  = r_packet_type;
    assign bus.sample_left  = r_sample_left;
    assign bus.sample_right = r_sample_right;
    assign bus.fifo_level   = r_level;

endmodule
`default_nettype wire
